// File: rtl/clint_timer_pkg.sv
// Shared register offsets and handshake state encoding for the CLINT timer.
package clint_timer_pkg;

    localparam int unsigned MTIME_LO    = 32'h00;
    localparam int unsigned MTIME_HI    = 32'h04;
    localparam int unsigned MTIMECMP_LO = 32'h08;
    localparam int unsigned MTIMECMP_HI = 32'h0C;
    localparam int unsigned MSIP        = 32'h10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

endpackage

// File: rtl/clint_prescaler.sv
// Divides i_clk by TICK_DIV: tick_o is high for one cycle when the count wraps.
// clr_i restarts the window from zero.
module clint_prescaler #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic clr_i,
    output logic tick_o
);

    localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

    logic [15:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clint_timer.sv
// Machine timer: 64-bit mtime/mtimecmp behind a 32-bit req/ack port, driving o_tip.
// Define CLINT_MSIP_EN to map the msip register at 0x10 and drive o_sip.
module clint_timer
    import clint_timer_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned TICK_DIV = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [XLEN-1:0]   i_wdata,
    output logic [XLEN-1:0]   o_rdata,
    output logic              o_ack,
    output logic              o_err,
    output logic              o_tip,
    output logic              o_sip
);

    state_t            state_q, state_d;
    logic [63:0]       mtime_q, mtime_d;
    logic [63:0]       mtimecmp_q, mtimecmp_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              tip_q;
    logic              tick, presc_clr;
    logic              accept, wr_en, addr_err;
    logic              hit_mtime_lo, hit_mtime_hi, hit_cmp_lo, hit_cmp_hi, hit_msip;
    logic              msip_val;
    logic [XLEN-1:0]   rd_mux;

    assign hit_mtime_lo = (i_addr == ADDR_W'(MTIME_LO));
    assign hit_mtime_hi = (i_addr == ADDR_W'(MTIME_HI));
    assign hit_cmp_lo   = (i_addr == ADDR_W'(MTIMECMP_LO));
    assign hit_cmp_hi   = (i_addr == ADDR_W'(MTIMECMP_HI));

`ifdef CLINT_MSIP_EN
    logic msip_q;

    assign hit_msip = (i_addr == ADDR_W'(MSIP));
    assign msip_val = msip_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            msip_q <= 1'b0;
        end else if (wr_en && hit_msip) begin
            msip_q <= i_wdata[0];
        end
    end
`else
    assign hit_msip = 1'b0;
    assign msip_val = 1'b0;
`endif

    assign addr_err = (i_addr[1:0] != 2'b00) ||
                      !(hit_mtime_lo || hit_mtime_hi || hit_cmp_lo || hit_cmp_hi || hit_msip);

    always_comb begin
        rd_mux = '0;
        if (hit_mtime_lo)      rd_mux = mtime_q[31:0];
        else if (hit_mtime_hi) rd_mux = mtime_q[63:32];
        else if (hit_cmp_lo)   rd_mux = mtimecmp_q[31:0];
        else if (hit_cmp_hi)   rd_mux = mtimecmp_q[63:32];
        else if (hit_msip)     rd_mux = {{(XLEN-1){1'b0}}, msip_val};
    end

    // Requests are only sampled in IDLE, so a held i_req completes once per two cycles.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (i_req) begin
                    state_d = ST_ACK;
                    accept  = 1'b1;
                    ack_d   = 1'b1;
                    err_d   = addr_err;
                    if (!i_we && !addr_err) begin
                        rdata_d = rd_mux;
                    end
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign wr_en     = accept && i_we && !addr_err;
    assign presc_clr = wr_en && (hit_mtime_lo || hit_mtime_hi);

    clint_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .clr_i  (presc_clr),
        .tick_o (tick)
    );

    // A software write to mtime takes priority over the tick in the same cycle.
    always_comb begin
        mtime_d = mtime_q;
        if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
        if (wr_en && hit_mtime_lo) begin
            mtime_d = {mtime_q[63:32], i_wdata};
        end else if (wr_en && hit_mtime_hi) begin
            mtime_d = {i_wdata, mtime_q[31:0]};
        end
    end

    always_comb begin
        mtimecmp_d = mtimecmp_q;
        if (wr_en && hit_cmp_lo) begin
            mtimecmp_d = {mtimecmp_q[63:32], i_wdata};
        end else if (wr_en && hit_cmp_hi) begin
            mtimecmp_d = {i_wdata, mtimecmp_q[31:0]};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q    <= ST_IDLE;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            rdata_q    <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            tip_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            rdata_q    <= rdata_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            tip_q      <= (mtime_q >= mtimecmp_q);
        end
    end

    assign o_rdata = rdata_q;
    assign o_ack   = ack_q;
    assign o_err   = err_q;
    assign o_tip   = tip_q;
    assign o_sip   = msip_val;

endmodule
